// File: rtl/hit_lives_ctrl_if.sv
// Signal bundle between the collision/game logic and hit_lives_ctrl.
// No valid/ready pairing: inputs are levels or 1-cycle pulses sampled on every
// clock edge, and outputs are registered levels except the 1-cycle o_Hit_Pulse.
interface hit_lives_ctrl_if #(
  parameter int LIVES_W = 4
);
  logic               i_Collision;
  logic               i_Game_Running;
  logic               i_Restart;
  logic               i_Level_Up;
  logic [LIVES_W-1:0] o_Lives;
  logic               o_Hit_Pulse;
  logic               o_Invuln;
  logic               o_Game_Over;

  modport master (
    output i_Collision, i_Game_Running, i_Restart, i_Level_Up,
    input  o_Lives, o_Hit_Pulse, o_Invuln, o_Game_Over
  );

  modport slave (
    input  i_Collision, i_Game_Running, i_Restart, i_Level_Up,
    output o_Lives, o_Hit_Pulse, o_Invuln, o_Game_Over
  );
endinterface

// File: rtl/hit_lives_ctrl.sv
// Turns raw collision overlap into discrete hits, owns the life counter and the
// post-hit invulnerability window. Define LIVES_BONUS_EN to let i_Level_Up add lives.
module hit_lives_ctrl #(
  parameter int LIVES_W         = 4,
  parameter int INIT_LIVES      = 3,
  parameter int MAX_LIVES       = 3,
  parameter int COOLDOWN_CYCLES = 25_000_000
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  hit_lives_ctrl_if.slave  bus,
  output logic [1:0]       o_State
);
  localparam int CNT_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ALIVE    = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_OVER     = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LIVES_W-1:0] lives_q;
  logic               hit_q;
  logic               invuln_q;
  logic               over_q;

  logic               hit;
  logic               bonus;
  logic [LIVES_W-1:0] lives_up;

  // Level-sampled: the cooldown window is what stops a held overlap re-hitting.
  assign hit = (state_q == ST_ALIVE) && bus.i_Game_Running && bus.i_Collision;

`ifdef LIVES_BONUS_EN
  assign bonus    = bus.i_Level_Up;
  assign lives_up = (lives_q < LIVES_W'(MAX_LIVES)) ? lives_q + LIVES_W'(1) : lives_q;
`else
  logic unused_level_up;
  assign bonus           = 1'b0;
  assign lives_up        = lives_q;
  assign unused_level_up = bus.i_Level_Up & (MAX_LIVES != 0);
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= ST_ALIVE;
      lives_q  <= LIVES_INIT;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      invuln_q <= 1'b0;
      over_q   <= 1'b0;
    end else if (bus.i_Restart) begin
      state_q  <= ST_ALIVE;
      lives_q  <= LIVES_INIT;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      invuln_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            hit_q <= 1'b1;
            if (bonus || (lives_q > LIVES_W'(1))) begin
              // A same-cycle level-up cancels the life this hit would take.
              lives_q  <= bonus ? lives_q : lives_q - LIVES_W'(1);
              cnt_q    <= CNT_LOAD;
              invuln_q <= 1'b1;
              state_q  <= ST_COOLDOWN;
            end else begin
              lives_q <= '0;
              over_q  <= 1'b1;
              state_q <= ST_OVER;
            end
          end else if (bonus) begin
            lives_q <= lives_up;
          end
        end
        ST_COOLDOWN: begin
          if (bonus) lives_q <= lives_up;
          if (cnt_q == '0) begin
            invuln_q <= 1'b0;
            state_q  <= ST_ALIVE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_Lives     = lives_q;
  assign bus.o_Hit_Pulse = hit_q;
  assign bus.o_Invuln    = invuln_q;
  assign bus.o_Game_Over = over_q;
  assign o_State         = state_q;
endmodule

// File: tb/tb_hit_lives_ctrl.sv
// Directed bench for hit_lives_ctrl with an 8-cycle cooldown.
module tb_hit_lives_ctrl;
  localparam int LIVES_W = 4;
`ifdef LIVES_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state;
  int         n_total;
  int         n_bad;
  logic [31:0] exp_q[$];

  hit_lives_ctrl_if #(.LIVES_W(LIVES_W)) bus ();

  hit_lives_ctrl #(
    .LIVES_W(LIVES_W),
    .INIT_LIVES(3),
    .MAX_LIVES(3),
    .COOLDOWN_CYCLES(8)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .bus(bus),
    .o_State(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic hit_once;
    bus.i_Collision = 1'b1;
    tick;
    bus.i_Collision = 1'b0;
  endtask

  task automatic restart;
    bus.i_Restart = 1'b1;
    tick;
    bus.i_Restart = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.i_Collision    = 1'b0;
    bus.i_Game_Running = 1'b0;
    bus.i_Restart      = 1'b0;
    bus.i_Level_Up     = 1'b0;

    #2;
    check("rst_lives", bus.o_Lives, 3);
    check("rst_pulse", bus.o_Hit_Pulse, 0);
    check("rst_invuln", bus.o_Invuln, 0);
    check("rst_over", bus.o_Game_Over, 0);
    check("rst_state", state, 0);
    tick;
    tick;
    rst = 1'b0;

    // 1: single hit, then the full invulnerability window
    bus.i_Game_Running = 1'b1;
    hit_once;
    check("t1_lives", bus.o_Lives, 2);
    check("t1_pulse", bus.o_Hit_Pulse, 1);
    check("t1_invuln", bus.o_Invuln, 1);
    check("t1_over", bus.o_Game_Over, 0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      check("t1_invuln_win", bus.o_Invuln, (k < 8));
      check("t1_pulse_low", bus.o_Hit_Pulse, 0);
    end
    check("t1_state_alive", state, 0);

    // 2: held collision; hits every 9 edges (edge 0, edge 9)
    restart;
    check("t2_start_lives", bus.o_Lives, 3);
    exp_q.push_back(0);
    exp_q.push_back(9);
    bus.i_Collision = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick;
      check("t2_pulse", bus.o_Hit_Pulse, (c == 0 || c == 9));
      check("t2_lives", bus.o_Lives, (c < 9) ? 2 : 1);
      check("t2_invuln", bus.o_Invuln, (c <= 7) || (c >= 9 && c <= 16));
      if (bus.o_Hit_Pulse) begin
        if (exp_q.size() > 0) check("t2_pulse_at", c, exp_q.pop_front());
        else check("t2_extra_pulse", c, 99);
      end
    end
    bus.i_Collision = 1'b0;
    check("t2_missing_pulses", exp_q.size(), 0);

    // 3: three spaced hits down to game over
    restart;
    for (int h = 0; h < 3; h++) begin
      hit_once;
      check("t3_pulse", bus.o_Hit_Pulse, 1);
      check("t3_lives", bus.o_Lives, 2 - h);
      check("t3_over", bus.o_Game_Over, (h == 2));
      repeat (8) tick;
    end
    check("t3_state_over", state, 2);
    check("t3_invuln_over", bus.o_Invuln, 0);
    bus.i_Collision = 1'b1;
    bus.i_Level_Up  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t3_hold_lives", bus.o_Lives, 0);
      check("t3_hold_pulse", bus.o_Hit_Pulse, 0);
      check("t3_hold_over", bus.o_Game_Over, 1);
    end
    bus.i_Level_Up = 1'b0;

    // 4: restart in OVER and restart racing a hit in ALIVE (collision still high)
    restart;
    check("t4_over_lives", bus.o_Lives, 3);
    check("t4_over_flag", bus.o_Game_Over, 0);
    check("t4_over_invuln", bus.o_Invuln, 0);
    check("t4_over_pulse", bus.o_Hit_Pulse, 0);
    check("t4_over_state", state, 0);
    restart;
    check("t4_alive_lives", bus.o_Lives, 3);
    check("t4_alive_pulse", bus.o_Hit_Pulse, 0);
    check("t4_alive_invuln", bus.o_Invuln, 0);
    bus.i_Collision = 1'b0;
    restart;

    // 5: async reset with the cooldown counter at 4
    hit_once;
    repeat (3) tick;
    check("t5_pre_invuln", bus.o_Invuln, 1);
    check("t5_pre_lives", bus.o_Lives, 2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_lives", bus.o_Lives, 3);
    check("t5_async_invuln", bus.o_Invuln, 0);
    check("t5_async_state", state, 0);
    bus.i_Collision = 1'b1;
    tick;
    check("t5_held_pulse", bus.o_Hit_Pulse, 0);
    check("t5_held_lives", bus.o_Lives, 3);
    bus.i_Collision = 1'b0;
    rst = 1'b0;
    tick;
    check("t5_after_pulse", bus.o_Hit_Pulse, 0);
    check("t5_after_invuln", bus.o_Invuln, 0);

    // 6: level-up, alone and together with a hit
    bus.i_Level_Up = 1'b1;
    tick;
    bus.i_Level_Up = 1'b0;
    check("t6_lvl_at_max", bus.o_Lives, 3);
    hit_once;
    check("t6_hit_lives", bus.o_Lives, 2);
    bus.i_Level_Up = 1'b1;
    tick;
    bus.i_Level_Up = 1'b0;
    check("t6_lvl_in_cool", bus.o_Lives, BONUS ? 3 : 2);
    restart;
    hit_once;
    repeat (8) tick;
    hit_once;
    repeat (8) tick;
    check("t6_one_life", bus.o_Lives, 1);
    bus.i_Collision = 1'b1;
    bus.i_Level_Up  = 1'b1;
    tick;
    bus.i_Collision = 1'b0;
    bus.i_Level_Up  = 1'b0;
    check("t6_combo_pulse", bus.o_Hit_Pulse, 1);
    check("t6_combo_lives", bus.o_Lives, BONUS ? 1 : 0);
    check("t6_combo_over", bus.o_Game_Over, BONUS ? 0 : 1);
    check("t6_combo_invuln", bus.o_Invuln, BONUS ? 1 : 0);
    tick;
    check("t6_pulse_single", bus.o_Hit_Pulse, 0);

    // report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
